// File: rtl/sm_product_accumulator.sv
// Sums blocks of sign-magnitude products in saturating two's complement
// and returns each block total in sign-magnitude form over valid/ready.
module sm_product_accumulator #(
  parameter int IN_W      = 64,
  parameter int ACC_W     = 72,
  parameter int BLOCK_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       out_count
);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  localparam logic signed [ACC_W:0] POS_MAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] NEG_MAX = -POS_MAX;
  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);

  state_t state;
  state_t state_nx;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] prod_v;
  logic [ACC_W-1:0] sat_sum;
  logic [ACC_W-1:0] sm_word;
  logic signed [ACC_W:0] raw_sum;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic ovf;
  logic ovf_nx;
  logic beat;
  logic clamp;
  logic blk_end;
  logic load;

  assign in_ready = (state == ACCUM);
  assign beat     = in_valid & in_ready;

  assign mag_ext = ACC_W'(in_prod[IN_W-2:0]);
  assign prod_v  = in_prod[IN_W-1] ? -mag_ext : mag_ext;

  // One guard bit so the raw sum never wraps before the clamp test.
  assign raw_sum = $signed({acc[ACC_W-1], acc})
                 + $signed({prod_v[ACC_W-1], prod_v});

  always_comb begin
    clamp   = 1'b0;
    sat_sum = raw_sum[ACC_W-1:0];
    unique case (1'b1)
      (raw_sum > POS_MAX): begin
        clamp   = 1'b1;
        sat_sum = POS_MAX[ACC_W-1:0];
      end
      (raw_sum < NEG_MAX): begin
        clamp   = 1'b1;
        sat_sum = NEG_MAX[ACC_W-1:0];
      end
      default: ;
    endcase
  end

  assign acc_nx  = beat ? sat_sum : acc;
  assign ovf_nx  = ovf | (beat & clamp);
  assign cnt_nx  = cnt + {7'd0, beat};
  assign blk_end = (beat && (cnt == LAST))
                 || (flush && ((cnt != 8'd0) || beat));

  // The clamp keeps |acc| below 2^(ACC_W-1), so the top bit is free
  // to carry the sign; zero comes out with sign 0.
  always_comb begin
    sm_word = acc_nx;
    if (acc_nx[ACC_W-1]) begin
      sm_word            = -acc_nx;
      sm_word[ACC_W-1]   = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      ACCUM: begin
        if (blk_end) begin
          load     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = ACCUM;
        end
      end
      default: state_nx = ACCUM;
    endcase
    if (clear) begin
      load     = 1'b0;
      state_nx = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (load) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b1;
      out_sum   <= sm_word;
      out_ovf   <= ovf_nx;
      out_count <= cnt_nx;
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      ovf <= ovf_nx;
      if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
